// File: rtl/decoder_rr_arbiter.sv
// Round-robin owner arbiter for a shared 3-to-8 decoder select path.
// Holds one-hot grant until release or hold timeout, then one dead cycle.
module decoder_rr_arbiter #(
  parameter int unsigned MAX_HOLD = 15,
  parameter int unsigned CNT_W    = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [7:0] req,
  output logic [7:0] gnt,
  output logic [2:0] gnt_idx,
  output logic       gnt_valid,
  output logic       timeout,
  output logic       busy
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_GRANT   = 2'd1;
  localparam logic [1:0] S_RELEASE = 2'd2;

  localparam logic [CNT_W-1:0] HOLD_LAST =
    CNT_W'(MAX_HOLD == 0 ? 0 : MAX_HOLD - 1);
  localparam logic [CNT_W-1:0] HOLD_SAT = '1;

  logic [1:0]       state_q, state_d;
  logic [2:0]       ptr_q, ptr_d;
  logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
  logic [2:0]       gnt_idx_q, gnt_idx_d;
  logic             gnt_valid_q, gnt_valid_d;
  logic             timeout_q, timeout_d;

  logic [2:0] win_idx;
  logic [2:0] cand;
  logic       win_found;
  logic       owner_req;
  logic       hold_done;

  // Rotating priority search starting at ptr, wrapping mod 8
  always_comb begin
    win_idx   = 3'd0;
    win_found = 1'b0;
    cand      = ptr_q;
    for (int k = 0; k < 8; k++) begin
      cand = ptr_q + 3'(k);
      if (!win_found && req[cand]) begin
        win_idx   = cand;
        win_found = 1'b1;
      end
    end
  end

  assign owner_req = req[gnt_idx_q];
  assign hold_done = (MAX_HOLD != 0) && (hold_cnt_q == HOLD_LAST);

  // Next-state and ownership bookkeeping
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    hold_cnt_d  = hold_cnt_q;
    gnt_idx_d   = gnt_idx_q;
    gnt_valid_d = gnt_valid_q;
    timeout_d   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (en && win_found) begin
          gnt_idx_d   = win_idx;
          gnt_valid_d = 1'b1;
          hold_cnt_d  = '0;
          state_d     = S_GRANT;
        end
      end
      S_GRANT: begin
        if (!owner_req || hold_done) begin
          gnt_valid_d = 1'b0;
          ptr_d       = gnt_idx_q + 3'd1;
          state_d     = S_RELEASE;
          timeout_d   = owner_req;
        end else if (hold_cnt_q != HOLD_SAT) begin
          hold_cnt_d = hold_cnt_q + CNT_W'(1);
        end
      end
      S_RELEASE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d     = S_IDLE;
        gnt_valid_d = 1'b0;
      end
    endcase
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      ptr_q       <= 3'd0;
      hold_cnt_q  <= '0;
      gnt_idx_q   <= 3'd0;
      gnt_valid_q <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      hold_cnt_q  <= hold_cnt_d;
      gnt_idx_q   <= gnt_idx_d;
      gnt_valid_q <= gnt_valid_d;
      timeout_q   <= timeout_d;
    end
  end

  assign gnt       = gnt_valid_q ? (8'd1 << gnt_idx_q) : 8'h00;
  assign gnt_idx   = gnt_idx_q;
  assign gnt_valid = gnt_valid_q;
  assign timeout   = timeout_q;
  assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_decoder_rr_arbiter.sv
// Bench for decoder_rr_arbiter: directed scenarios plus random traffic
// checked against an owner/dead-time reference model.
module tb_decoder_rr_arbiter;

  localparam int MH = 4;

  logic       clk;
  logic       rst;
  logic       en;
  logic [7:0] req;
  logic [7:0] gnt;
  logic [2:0] gnt_idx;
  logic       gnt_valid;
  logic       timeout;
  logic       busy;

  int checks;
  int failures;

  // reference model: who owns, how long, where the search starts next
  int m_owner;
  int m_last;
  int m_next;
  int m_cycles;
  int m_dead;
  bit m_to;

  decoder_rr_arbiter #(.MAX_HOLD(MH), .CNT_W(4)) dut (
    .clk(clk),
    .rst(rst),
    .en(en),
    .req(req),
    .gnt(gnt),
    .gnt_idx(gnt_idx),
    .gnt_valid(gnt_valid),
    .timeout(timeout),
    .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic int pick(logic [7:0] r, int from);
    for (int k = 0; k < 8; k++) begin
      int i;
      i = (from + k) % 8;
      if (r[i]) return i;
    end
    return -1;
  endfunction

  task automatic model_edge(logic r, logic e, logic [7:0] q);
    if (r) begin
      m_owner = -1; m_last = 0; m_next = 0;
      m_cycles = 0; m_dead = 0; m_to = 0;
    end else if (m_owner >= 0) begin
      if (!q[m_owner] || (MH != 0 && m_cycles == MH)) begin
        m_to = q[m_owner];
        m_next = (m_owner + 1) % 8;
        m_owner = -1;
        m_dead = 1;
      end else begin
        m_cycles++;
        m_to = 0;
      end
    end else if (m_dead > 0) begin
      m_dead--;
      m_to = 0;
    end else begin
      m_to = 0;
      if (e && q != 8'h00) begin
        m_owner = pick(q, m_next);
        m_last = m_owner;
        m_cycles = 1;
      end
    end
  endtask

  function automatic logic [13:0] exp_vec();
    logic [7:0] g;
    g = (m_owner >= 0) ? (8'd1 << m_owner) : 8'h00;
    return {g, 3'(m_last), m_owner >= 0, m_to,
            (m_owner >= 0) || (m_dead > 0)};
  endfunction

  function automatic logic [13:0] obs_vec();
    return {gnt, gnt_idx, gnt_valid, timeout, busy};
  endfunction

  task automatic step(logic r, logic e, logic [7:0] q);
    rst = r; en = e; req = q;
    @(posedge clk);
    model_edge(r, e, q);
    #1;
  endtask

  task automatic test_reset();
    step(1, 1, 8'h00);
    step(1, 1, 8'h00);
    checks++;
    if (obs_vec() !== 14'h0) begin
      failures++;
      $display("FAIL reset_outputs got=%h want=%h", obs_vec(), 14'h0);
    end
    for (int i = 0; i < 10; i++) begin
      step(0, 1, 8'h00);
      checks++;
      if (obs_vec() !== exp_vec() || busy !== 1'b0) begin
        failures++;
        $display("FAIL idle_cyc%0d got=%h want=%h", i, obs_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_single();
    step(0, 1, 8'h10);
    checks++;
    if (gnt !== 8'h10 || gnt_idx !== 3'd4) begin
      failures++;
      $display("FAIL single_grant got=%h/%0d want=10/4", gnt, gnt_idx);
    end
    for (int i = 0; i < 2; i++) begin
      step(0, 1, 8'h10);
      checks++;
      if (obs_vec() !== exp_vec()) begin
        failures++;
        $display("FAIL single_hold got=%h want=%h", obs_vec(), exp_vec());
      end
    end
    step(0, 1, 8'h00);
    checks++;
    if (gnt !== 8'h00 || gnt_idx !== 3'd4 || busy !== 1'b1) begin
      failures++;
      $display("FAIL single_release got=%h/%0d/%b want=00/4/1",
               gnt, gnt_idx, busy);
    end
    step(0, 1, 8'h00);
    step(0, 1, 8'hFF);
    checks++;
    if (gnt !== 8'h20 || obs_vec() !== exp_vec()) begin
      failures++;
      $display("FAIL single_next_ptr got=%h want=20", gnt);
    end
    step(0, 1, 8'h00);
    step(0, 1, 8'h00);
    step(0, 1, 8'h00);
  endtask

  task automatic test_rotation();
    int order[$];
    int zeros;
    bit prev_v;
    bit wrap;
    logic [7:0] q;
    zeros = 0;
    prev_v = 0;
    wrap = 0;
    for (int c = 0; c < 40; c++) begin
      q = 8'hFF;
      if (m_owner >= 0 && m_cycles == 2) q[m_owner] = 1'b0;
      step(0, 1, q);
      checks++;
      if (obs_vec() !== exp_vec()) begin
        failures++;
        $display("FAIL rot_cyc%0d got=%h want=%h", c, obs_vec(), exp_vec());
      end
      if (gnt_valid && !prev_v) begin
        order.push_back(int'(gnt_idx));
        if (order.size() > 1) begin
          checks++;
          if (zeros != 2) begin
            failures++;
            $display("FAIL rot_gap got=%0d want=2", zeros);
          end
        end
      end
      zeros = (gnt == 8'h00) ? zeros + 1 : 0;
      prev_v = gnt_valid;
    end
    checks++;
    if (order.size() < 9) begin
      failures++;
      $display("FAIL rot_count got=%0d want>=9", order.size());
    end
    for (int i = 1; i < order.size(); i++) begin
      checks++;
      if (order[i] != (order[i-1] + 1) % 8) begin
        failures++;
        $display("FAIL rot_order got=%0d want=%0d",
                 order[i], (order[i-1] + 1) % 8);
      end
      if (order[i-1] == 7 && order[i] == 0) wrap = 1;
    end
    checks++;
    if (!wrap) begin
      failures++;
      $display("FAIL rot_wrap got=0 want=1");
    end
    for (int i = 0; i < 4; i++) step(0, 1, 8'h00);
  endtask

  task automatic test_timeout();
    int gcyc;
    int pulses;
    gcyc = 0;
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      step(0, 1, 8'h02);
      checks++;
      if (obs_vec() !== exp_vec()) begin
        failures++;
        $display("FAIL to_cyc%0d got=%h want=%h", i, obs_vec(), exp_vec());
      end
      if (gnt == 8'h02) gcyc++;
      if (timeout) pulses++;
    end
    checks++;
    if (gcyc != MH || pulses != 1) begin
      failures++;
      $display("FAIL to_len got=%0d/%0d want=%0d/1", gcyc, pulses, MH);
    end
    step(0, 1, 8'h06);
    checks++;
    if (gnt !== 8'h04) begin
      failures++;
      $display("FAIL to_next got=%h want=04", gnt);
    end
    step(0, 1, 8'h00);
    step(0, 1, 8'h00);
    step(0, 1, 8'h00);
  endtask

  task automatic test_enable();
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 8'h08);
      checks++;
      if (gnt !== 8'h00 || busy !== 1'b0) begin
        failures++;
        $display("FAIL en_gate got=%h want=00", gnt);
      end
    end
    step(0, 1, 8'h08);
    checks++;
    if (gnt !== 8'h08) begin
      failures++;
      $display("FAIL en_rise got=%h want=08", gnt);
    end
    for (int i = 0; i < 2; i++) begin
      step(0, 0, 8'h08);
      checks++;
      if (gnt !== 8'h08 || obs_vec() !== exp_vec()) begin
        failures++;
        $display("FAIL en_fall_hold got=%h want=08", gnt);
      end
    end
    step(0, 0, 8'h00);
    checks++;
    if (gnt !== 8'h00 || timeout !== 1'b0) begin
      failures++;
      $display("FAIL en_release got=%h/%b want=00/0", gnt, timeout);
    end
    step(0, 1, 8'h00);
    step(0, 1, 8'h00);
  endtask

  task automatic test_reset_mid();
    step(0, 1, 8'h20);
    step(0, 1, 8'h20);
    checks++;
    if (gnt !== 8'h20) begin
      failures++;
      $display("FAIL rm_pre got=%h want=20", gnt);
    end
    step(1, 1, 8'h20);
    checks++;
    if (obs_vec() !== 14'h0) begin
      failures++;
      $display("FAIL rm_reset got=%h want=0000", obs_vec());
    end
    step(0, 1, 8'h21);
    checks++;
    if (gnt !== 8'h01 || gnt_idx !== 3'd0) begin
      failures++;
      $display("FAIL rm_after got=%h want=01", gnt);
    end
    step(0, 1, 8'h00);
    step(0, 1, 8'h00);
    step(0, 1, 8'h00);
  endtask

  task automatic test_random();
    logic [7:0] q;
    logic r;
    logic e;
    q = 8'h00;
    for (int c = 0; c < 500; c++) begin
      if ($urandom_range(0, 3) == 0) q = 8'($urandom);
      if ($urandom_range(0, 7) == 0) q = 8'h00;
      r = ($urandom_range(0, 59) == 0);
      e = ($urandom_range(0, 3) != 0);
      step(r, e, q);
      checks++;
      if (obs_vec() !== exp_vec() || !$onehot0(gnt)) begin
        failures++;
        $display("FAIL rand_cyc%0d got=%h want=%h", c, obs_vec(), exp_vec());
      end
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    clk = 0;
    rst = 1;
    en = 0;
    req = 8'h00;
    checks = 0;
    failures = 0;
    m_owner = -1; m_last = 0; m_next = 0;
    m_cycles = 0; m_dead = 0; m_to = 0;
    #1;
    test_reset();
    test_single();
    test_rotation();
    test_timeout();
    test_enable();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
